// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan controller.
//   scan_state_e : scan FSM states (BLANK gap, SHOW digit)
//   SEG_BLANK    : all-segments-off cathode pattern (active-low)
//   SEG_TABLE    : hex digit -> {g,f,e,d,c,b,a} active-low segment table
//   seg_decode() : table lookup used by the scan output stage
package seg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] hex);
    return SEG_TABLE[hex];
  endfunction

endpackage

// File: rtl/seg_debounce.sv
// One push-button conditioner: 2-flop synchroniser, stability counter and
// rising-edge detector on the debounced level.
//   clk, rst : system clock, synchronous active-high reset
//   btn      : raw asynchronous button input (active-high)
//   rise     : high for one cycle after the debounced level goes 0 -> 1
// Parameter DB_CYC: cycles the synchronised level must differ from the
// debounced level before the debounced level follows it.
module seg_debounce #(
  parameter int DB_CYC = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  localparam int CW = (DB_CYC > 2) ? $clog2(DB_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYC - 1);

  logic          btn_p0;
  logic          btn_p1;
  logic          lvl_q;
  logic          lvl_p2;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_p0 <= 1'b0;
      btn_p1 <= 1'b0;
      lvl_q  <= 1'b0;
      lvl_p2 <= 1'b0;
      cnt_q  <= '0;
    end else begin
      // synchroniser stages
      btn_p0 <= btn;
      btn_p1 <= btn_p0;
      // debounce stage: counter only runs while the synced level disagrees
      if (btn_p1 == lvl_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        lvl_q <= btn_p1;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      // edge-detect stage
      lvl_p2 <= lvl_q;
    end
  end

  assign rise = lvl_q & ~lvl_p2;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Digit store and multiplexed scan driver for a 4-digit common-anode
// seven-segment display.
//   clk, rst   : system clock, synchronous active-high reset
//   switch     : hex value to load (asynchronous)
//   btn        : per-digit load buttons (asynchronous, active-high)
//   led        : registered copy of the synchronised switch value
//   cathodes   : {g,f,e,d,c,b,a}, active-low
//   anodes     : digit enables, active-low; digit i drives anodes[3-i]
//   load_pulse : one-cycle pulse on bit i when digit i is written
// Build option: define SEG_LZ_BLANK_EN to blank leading zeros (digit 0 is
// the most significant); digit 3 is always shown.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int TICK_DIV  = 100000,
  parameter int BLANK_CYC = 64,
  parameter int DB_CYC    = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] switch,
  input  logic [3:0] btn,
  output logic [3:0] led,
  output logic [6:0] cathodes,
  output logic [3:0] anodes,
  output logic [3:0] load_pulse
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  logic [3:0]       sw_p0;
  logic [3:0]       sw_p1;
  logic [3:0]       rise;
  logic [3:0]       digit_q [4];
  logic [3:0]       valid_q;
  logic [3:0]       lz;
  logic [CNT_W-1:0] cnt_q;
  logic             slot_end;
  scan_state_e      state_q;
  scan_state_e      state_d;
  logic [1:0]       idx_q;
  logic [1:0]       idx_d;
  logic [3:0]       an_d;
  logic [6:0]       cat_d;

  // switch synchroniser stages; pure data, so no reset
  always_ff @(posedge clk) begin
    sw_p0 <= switch;
    sw_p1 <= sw_p0;
  end

  always_ff @(posedge clk) begin
    if (rst) led <= '0;
    else     led <= sw_p1;
  end

  for (genvar i = 0; i < 4; i++) begin : g_db
    seg_debounce #(.DB_CYC(DB_CYC)) u_db (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn[i]),
      .rise (rise[i])
    );
  end

  // digit store: a debounced press captures the synced switch value
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      load_pulse <= '0;
      for (int i = 0; i < 4; i++) digit_q[i] <= '0;
    end else begin
      load_pulse <= rise;
      for (int i = 0; i < 4; i++) begin
        if (rise[i]) begin
          digit_q[i] <= sw_p1;
          valid_q[i] <= 1'b1;
        end
      end
    end
  end

  // slot prescaler
  assign slot_end = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst)           cnt_q <= '0;
    else if (slot_end) cnt_q <= '0;
    else               cnt_q <= cnt_q + 1'b1;
  end

  // scan FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BLANK;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      BLANK: if (cnt_q == BLANK_LAST) state_d = SHOW;
      SHOW: begin
        if (slot_end) begin
          state_d = BLANK;
          idx_d   = idx_q + 2'd1;
        end
      end
      default: state_d = BLANK;
    endcase
  end

`ifdef SEG_LZ_BLANK_EN
  // A digit is a leading zero while every valid digit up to and including
  // it is zero; invalid digits are blank anyway so they do not break the run.
  logic zero_run;
  always_comb begin
    lz       = '0;
    zero_run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      zero_run = zero_run && (!valid_q[i] || (digit_q[i] == 4'h0));
      lz[i]    = zero_run;
    end
  end
`else
  assign lz = '0;
`endif

  always_comb begin
    an_d  = 4'b1111;
    cat_d = SEG_BLANK;
    if (state_q == SHOW) begin
      an_d = ~(4'b1000 >> idx_q);
      if (valid_q[idx_q] && !lz[idx_q]) cat_d = seg_decode(digit_q[idx_q]);
    end
  end

  // output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      anodes   <= 4'b1111;
      cathodes <= SEG_BLANK;
    end else begin
      anodes   <= an_d;
      cathodes <= cat_d;
    end
  end

endmodule
